apb_arb_mux: RTL and testbench
==============================

Name: apb_arb_mux

Overview:
N-requester to 1-completer APB mux with a selectable arbitration policy, full-width PSTRB/PPROT forwarding and an access watchdog. Each requester port is an APB completer-side interface. The block serialises transfers onto a single APB requester port driving a downstream slave or bridge. It is the parametrised successor to the fixed round-robin mux. It adds a fixed-priority mode, a timeout that converts a hung slave into PSLVERR, and grant/status observability.

Parameters:
NUM_MASTERS, 9, number of requester ports (2..32)
ADDR_W, 32, PADDR width
DATA_W, 32, PWDATA/PRDATA width (multiple of 8)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 64, ACCESS cycles before forced error completion; 0 disables the watchdog

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL_s  in  NUM_MASTERS  per-requester select
PENABLE_s  in  NUM_MASTERS  per-requester enable
PWRITE_s  in  NUM_MASTERS  per-requester direction
PADDR_s  in  [NUM_MASTERS][ADDR_W]  addresses
PWDATA_s  in  [NUM_MASTERS][DATA_W]  write data
PSTRB_s  in  [NUM_MASTERS][DATA_W/8]  write strobes
PPROT_s  in  [NUM_MASTERS][3]  protection
PRDATA_s  out  [NUM_MASTERS][DATA_W]  read data back to each requester
PREADY_s  out  NUM_MASTERS  per-requester ready
PSLVERR_s  out  NUM_MASTERS  per-requester error
PSEL_m, PENABLE_m, PWRITE_m  out  1 each  downstream controls
PADDR_m  out  ADDR_W  downstream address
PWDATA_m  out  DATA_W  downstream write data
PSTRB_m  out  DATA_W/8  downstream strobes
PPROT_m  out  3  downstream protection
PRDATA_m  in  DATA_W  downstream read data
PREADY_m  in  1  downstream ready
PSLVERR_m  in  1  downstream error
grant_idx  out  $clog2(NUM_MASTERS)  index of current or last grant
busy  out  1  high in SETUP/ACCESS/RESP
timeout_pulse  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async on PRESETn low): FSM = IDLE; all outputs 0; RR pointer = 0; watchdog counter = 0. Reset mid-transfer drops PSEL_m/PENABLE_m immediately. No response is issued to the abandoned requester.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Request vector = PSEL_s. If nonzero, choose winner g.
  - Latch PADDR/PWRITE/PWDATA/PSTRB/PPROT of g into output registers.
  - grant_idx <= g; go to SETUP.
- SETUP: PSEL_m=1, PENABLE_m=0 for exactly one cycle; go to ACCESS.
- ACCESS:
  - PSEL_m=1, PENABLE_m=1; watchdog increments each cycle.
  - If PREADY_m=1: capture PRDATA_m (reads only; writes return 0) and PSLVERR_m; go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1: go to RESP with error=1, rdata=0, and pulse timeout_pulse.
- RESP:
  - PSEL_m=PENABLE_m=0.
  - PREADY_s[g]=1 for exactly one cycle, with PRDATA_s[g]/PSLVERR_s[g] = captured values.
  - Next state is IDLE; the counter clears.
- Minimum transfer is 4 cycles from request sample to PREADY_s (IDLE→SETUP→ACCESS→RESP). Back-to-back grants leave one IDLE cycle between transfers.
- Non-granted requesters see PREADY_s=0 and PSLVERR_s=0. PRDATA_s[i] holds its last delivered value.
- Requester PENABLE_s is not used for arbitration. Requesters must hold their signals stable until PREADY_s.
- Round-robin: search from the pointer upward, wrapping mod NUM_MASTERS. After a grant to g, pointer = (g+1) mod NUM_MASTERS, so g+1 wraps to 0 at NUM_MASTERS-1.
- Fixed priority: lowest set index wins. The pointer is unused.
- Simultaneous requests are resolved only in IDLE. A request arriving during SETUP/ACCESS/RESP waits.
- A requester that deasserts PSEL_s before grant is simply not selected.
- PSTRB_m is forced to 0 on reads.

Decomposition:
- Package apb_arb_pkg holds:
  - the FSM state enum;
  - ARB_RR/ARB_FIXED localparams;
  - PPROT_W=3.
- Sub-module apb_rr_arbiter: pure combinational winner select from (req, pointer, mode), outputting a one-hot grant and its index. The mux top owns the FSM, registers and watchdog.

Test Plan:
- Single write: M0 writes 0x1000_0000/0xAAAA_AAAA, PSTRB 0xF, slave always ready → PSEL_m one cycle before PENABLE_m; PWDATA_m=0xAAAA_AAAA; PSTRB_m=0xF; PREADY_s[0] one cycle; PSLVERR_s[0]=0.
- RR contention: M0, M1, M2 read 0x4000_0000/0x5000_0000/0x6000_0000 in the same cycle, slave returns {8'hDE, addr[23:0]} → grants in order 0, 1, 2. PRDATA_s[1]=0xDE00_0000.
- RR wrap: grant M8, then M0 and M8 request together → M0 wins (pointer wrapped to 0).
- Fixed priority (ARB_MODE=1): M7 and M4 request together, and M4 re-requests immediately after completing → M4 served twice before M7.
- Timeout (TIMEOUT_CYCLES=8): slave never asserts PREADY_m → after 8 ACCESS cycles, timeout_pulse=1, PREADY_s[g]=1, PSLVERR_s[g]=1, PRDATA_s[g]=0, FSM back to IDLE.
- Reset mid-ACCESS: assert PRESETn low in ACCESS → PSEL_m/PENABLE_m/busy go 0 asynchronously. No PREADY_s is issued. The first post-reset RR contention grants M0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the N-to-1 APB arbitrating mux.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int PPROT_W   = 3;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational winner select: round-robin from a pointer, or lowest index first.
module apb_rr_arbiter #(
  parameter int NUM_MASTERS = 9,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic                   fixed_prio,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_valid
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk candidates in priority order; the first requesting one wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s       = fixed_prio ? IDX_W'(i) : IDX_W'((int'(ptr) + i) % NUM_MASTERS);
      hit_s        = !gnt_valid && req[cand_s];
      gnt[cand_s]  = gnt[cand_s] | hit_s;
      gnt_idx      = hit_s ? cand_s : gnt_idx;
      gnt_valid    = gnt_valid | hit_s;
    end
  end

endmodule

// File: rtl/apb_arb_mux.sv
// N-requester to 1-completer APB mux with RR/fixed arbitration and an ACCESS watchdog.
module apb_arb_mux
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 9,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   PCLK,
  input  logic                                   PRESETn,
  input  logic [NUM_MASTERS-1:0]                 PSEL_s,
  input  logic [NUM_MASTERS-1:0]                 PENABLE_s,
  input  logic [NUM_MASTERS-1:0]                 PWRITE_s,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]     PADDR_s,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]     PWDATA_s,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]   PSTRB_s,
  input  logic [NUM_MASTERS-1:0][PPROT_W-1:0]    PPROT_s,
  output logic [NUM_MASTERS-1:0][DATA_W-1:0]     PRDATA_s,
  output logic [NUM_MASTERS-1:0]                 PREADY_s,
  output logic [NUM_MASTERS-1:0]                 PSLVERR_s,
  output logic                                   PSEL_m,
  output logic                                   PENABLE_m,
  output logic                                   PWRITE_m,
  output logic [ADDR_W-1:0]                      PADDR_m,
  output logic [DATA_W-1:0]                      PWDATA_m,
  output logic [DATA_W/8-1:0]                    PSTRB_m,
  output logic [PPROT_W-1:0]                     PPROT_m,
  input  logic [DATA_W-1:0]                      PRDATA_m,
  input  logic                                   PREADY_m,
  input  logic                                   PSLVERR_m,
  output logic [$clog2(NUM_MASTERS)-1:0]         grant_idx,
  output logic                                   busy,
  output logic                                   timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic FIXED_PRIO = (ARB_MODE == ARB_FIXED);
  localparam logic WD_EN      = (TIMEOUT_CYCLES != 0);

  apb_state_e               state_r;
  logic [IDX_W-1:0]         ptr_r;
  logic [NUM_MASTERS-1:0]   gnt_oh_r;
  logic [CNT_W-1:0]         cnt_r;

  logic [NUM_MASTERS-1:0]   arb_gnt_s;
  logic [IDX_W-1:0]         arb_idx_s;
  logic                     arb_valid_s;
  logic                     rsp_fire_s;
  logic                     rsp_to_s;
  logic                     rsp_err_s;
  logic [DATA_W-1:0]        rsp_rdata_s;
  logic                     unused_s;

  // Requester PENABLE plays no part in arbitration.
  assign unused_s = ^PENABLE_s;

  apb_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req        (PSEL_s),
    .ptr        (ptr_r),
    .fixed_prio (FIXED_PRIO),
    .gnt        (arb_gnt_s),
    .gnt_idx    (arb_idx_s),
    .gnt_valid  (arb_valid_s)
  );

  // ACCESS completion: slave ready wins over a same-cycle watchdog expiry.
  always_comb begin
    rsp_to_s    = 1'b0;
    rsp_fire_s  = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_rdata_s = '0;
    if (state_r == ST_ACCESS) begin
      rsp_to_s    = WD_EN && !PREADY_m && (cnt_r == CNT_LAST);
      rsp_fire_s  = PREADY_m || rsp_to_s;
      rsp_err_s   = PREADY_m ? PSLVERR_m : 1'b1;
      rsp_rdata_s = (PREADY_m && !PWRITE_m) ? PRDATA_m : '0;
    end else begin
      rsp_fire_s  = 1'b0;
    end
  end

  // Transfer FSM with all downstream and requester-side outputs registered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      gnt_oh_r      <= '0;
      cnt_r         <= '0;
      PRDATA_s      <= '0;
      PREADY_s      <= '0;
      PSLVERR_s     <= '0;
      PSEL_m        <= 1'b0;
      PENABLE_m     <= 1'b0;
      PWRITE_m      <= 1'b0;
      PADDR_m       <= '0;
      PWDATA_m      <= '0;
      PSTRB_m       <= '0;
      PPROT_m       <= '0;
      grant_idx     <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      PREADY_s      <= '0;
      PSLVERR_s     <= '0;
      timeout_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            gnt_oh_r  <= arb_gnt_s;
            grant_idx <= arb_idx_s;
            PWRITE_m  <= PWRITE_s[arb_idx_s];
            PADDR_m   <= PADDR_s[arb_idx_s];
            PWDATA_m  <= PWDATA_s[arb_idx_s];
            PSTRB_m   <= PWRITE_s[arb_idx_s] ? PSTRB_s[arb_idx_s] : '0;
            PPROT_m   <= PPROT_s[arb_idx_s];
            PSEL_m    <= 1'b1;
            PENABLE_m <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_SETUP;
            if (!FIXED_PRIO) begin
              ptr_r <= (arb_idx_s == IDX_W'(NUM_MASTERS - 1)) ? '0 : arb_idx_s + IDX_W'(1);
            end
          end
        end
        ST_SETUP: begin
          PENABLE_m <= 1'b1;
          state_r   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (rsp_fire_s) begin
            PSEL_m        <= 1'b0;
            PENABLE_m     <= 1'b0;
            PREADY_s      <= gnt_oh_r;
            PSLVERR_s     <= gnt_oh_r & {NUM_MASTERS{rsp_err_s}};
            timeout_pulse <= rsp_to_s;
            state_r       <= ST_RESP;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (gnt_oh_r[i]) PRDATA_s[i] <= rsp_rdata_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          cnt_r   <= '0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          PSEL_m    <= 1'b0;
          PENABLE_m <= 1'b0;
          busy      <= 1'b0;
          cnt_r     <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_mux.sv
// Directed bench: RR instance (watchdog 8) and fixed-priority instance share requester inputs.
module tb_apb_arb_mux;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic [8:0]        psel_s, penable_s, pwrite_s;
  logic [8:0][31:0]  paddr_s, pwdata_s;
  logic [8:0][3:0]   pstrb_s;
  logic [8:0][2:0]   pprot_s;
  logic              slave_ready, slave_err;

  logic [8:0][31:0]  rr_prdata_s, fp_prdata_s;
  logic [8:0]        rr_pready_s, rr_pslverr_s, fp_pready_s, fp_pslverr_s;
  logic              rr_psel_m, rr_penable_m, rr_pwrite_m, fp_psel_m, fp_penable_m, fp_pwrite_m;
  logic [31:0]       rr_paddr_m, rr_pwdata_m, fp_paddr_m, fp_pwdata_m;
  logic [3:0]        rr_pstrb_m, fp_pstrb_m;
  logic [2:0]        rr_pprot_m, fp_pprot_m;
  logic [31:0]       rr_prdata_m, fp_prdata_m;
  logic [3:0]        rr_grant, fp_grant;
  logic              rr_busy, fp_busy, rr_timeout, fp_timeout;

  assign rr_prdata_m = {8'hDE, rr_paddr_m[23:0]};
  assign fp_prdata_m = {8'hDE, fp_paddr_m[23:0]};

  int pass_cnt = 0;
  int total_cnt = 0;

  apb_arb_mux #(.NUM_MASTERS(9), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL_s(psel_s), .PENABLE_s(penable_s), .PWRITE_s(pwrite_s),
    .PADDR_s(paddr_s), .PWDATA_s(pwdata_s), .PSTRB_s(pstrb_s), .PPROT_s(pprot_s),
    .PRDATA_s(rr_prdata_s), .PREADY_s(rr_pready_s), .PSLVERR_s(rr_pslverr_s),
    .PSEL_m(rr_psel_m), .PENABLE_m(rr_penable_m), .PWRITE_m(rr_pwrite_m), .PADDR_m(rr_paddr_m),
    .PWDATA_m(rr_pwdata_m), .PSTRB_m(rr_pstrb_m), .PPROT_m(rr_pprot_m), .PRDATA_m(rr_prdata_m),
    .PREADY_m(slave_ready), .PSLVERR_m(slave_err), .grant_idx(rr_grant), .busy(rr_busy),
    .timeout_pulse(rr_timeout)
  );

  apb_arb_mux #(.NUM_MASTERS(9), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYCLES(64)) dut_fp (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL_s(psel_s), .PENABLE_s(penable_s), .PWRITE_s(pwrite_s),
    .PADDR_s(paddr_s), .PWDATA_s(pwdata_s), .PSTRB_s(pstrb_s), .PPROT_s(pprot_s),
    .PRDATA_s(fp_prdata_s), .PREADY_s(fp_pready_s), .PSLVERR_s(fp_pslverr_s),
    .PSEL_m(fp_psel_m), .PENABLE_m(fp_penable_m), .PWRITE_m(fp_pwrite_m), .PADDR_m(fp_paddr_m),
    .PWDATA_m(fp_pwdata_m), .PSTRB_m(fp_pstrb_m), .PPROT_m(fp_pprot_m), .PRDATA_m(fp_prdata_m),
    .PREADY_m(slave_ready), .PSLVERR_m(slave_err), .grant_idx(fp_grant), .busy(fp_busy),
    .timeout_pulse(fp_timeout)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p);
    psel_s[i] = 1'b1; penable_s[i] = 1'b0; pwrite_s[i] = wr;
    paddr_s[i] = a; pwdata_s[i] = d; pstrb_s[i] = s; pprot_s[i] = p;
  endtask

  task automatic drop(input int i);
    psel_s[i] = 1'b0;
    penable_s[i] = 1'b0;
  endtask

  // Bounded wait for any PREADY_s; rdy stays 0 if the bound expires.
  task automatic wait_ready(input bit use_fp, output logic [8:0] rdy, output int ticks);
    rdy = '0;
    ticks = 0;
    while (rdy == 9'd0 && ticks < 30) begin
      tick();
      ticks++;
      rdy = use_fp ? fp_pready_s : rr_pready_s;
    end
  endtask

  task automatic apply_reset();
    PRESETn = 1'b0;
    psel_s = '0; penable_s = '0; pwrite_s = '0;
    paddr_s = '0; pwdata_s = '0; pstrb_s = '0; pprot_s = '0;
    slave_ready = 1'b1; slave_err = 1'b0;
    tick(); tick();
    PRESETn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if ({rr_psel_m, rr_penable_m, rr_busy, rr_timeout} !== 4'b0) $display("FAIL reset_rr_ctrl got=%b exp=0000", {rr_psel_m, rr_penable_m, rr_busy, rr_timeout}); else pass_cnt++;
    total_cnt++; if ({rr_pready_s, rr_pslverr_s, rr_grant} !== 22'd0) $display("FAIL reset_rr_resp got=%h exp=0", {rr_pready_s, rr_pslverr_s, rr_grant}); else pass_cnt++;
    total_cnt++; if ({rr_prdata_s, rr_paddr_m, rr_pwdata_m} !== '0) $display("FAIL reset_rr_data got=nonzero exp=0"); else pass_cnt++;
    total_cnt++; if ({fp_psel_m, fp_penable_m, fp_busy, fp_grant} !== 7'b0) $display("FAIL reset_fp_ctrl got=%b exp=0", {fp_psel_m, fp_penable_m, fp_busy, fp_grant}); else pass_cnt++;
  endtask

  task automatic test_single_write();
    logic [8:0] rdy; int t;
    apply_reset();
    req(0, 1'b1, 32'h1000_0000, 32'hAAAA_AAAA, 4'hF, 3'b010);
    tick();
    total_cnt++; if ({rr_psel_m, rr_penable_m, rr_pwrite_m, rr_busy} !== 4'b1011) $display("FAIL wr_setup_ctrl got=%b exp=1011", {rr_psel_m, rr_penable_m, rr_pwrite_m, rr_busy}); else pass_cnt++;
    total_cnt++; if ({rr_paddr_m, rr_pwdata_m, rr_pstrb_m} !== {32'h1000_0000, 32'hAAAA_AAAA, 4'hF}) $display("FAIL wr_setup_data got=%h/%h/%h exp=10000000/aaaaaaaa/f", rr_paddr_m, rr_pwdata_m, rr_pstrb_m); else pass_cnt++;
    penable_s[0] = 1'b1;
    tick();
    total_cnt++; if ({rr_psel_m, rr_penable_m} !== 2'b11) $display("FAIL wr_access_ctrl got=%b exp=11", {rr_psel_m, rr_penable_m}); else pass_cnt++;
    tick();
    total_cnt++; if ({rr_pready_s, rr_pslverr_s, rr_psel_m} !== {9'h001, 9'h000, 1'b0}) $display("FAIL wr_resp got=%h/%h/%b exp=001/000/0", rr_pready_s, rr_pslverr_s, rr_psel_m); else pass_cnt++;
    drop(0);
    tick();
    total_cnt++; if ({rr_pready_s, rr_busy} !== 10'd0) $display("FAIL wr_idle got=%h/%b exp=000/0", rr_pready_s, rr_busy); else pass_cnt++;
    // read: strobes suppressed downstream, PPROT forwarded
    req(0, 1'b0, 32'h1000_0044, 32'h0, 4'hF, 3'b101);
    tick();
    total_cnt++; if ({rr_pstrb_m, rr_pprot_m, rr_pwrite_m} !== {4'h0, 3'b101, 1'b0}) $display("FAIL rd_strb_prot got=%h/%b/%b exp=0/101/0", rr_pstrb_m, rr_pprot_m, rr_pwrite_m); else pass_cnt++;
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_prdata_s[0]} !== {9'h001, 32'hDE00_0044}) $display("FAIL rd_data got=%h/%h exp=001/de000044", rdy, rr_prdata_s[0]); else pass_cnt++;
    drop(0);
    tick();
    // write with slave error: error forwarded, read data cleared
    slave_err = 1'b1;
    req(0, 1'b1, 32'h1000_0008, 32'h5555_5555, 4'h3, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_pslverr_s, rr_prdata_s[0]} !== {9'h001, 9'h001, 32'h0}) $display("FAIL wr_err got=%h/%h/%h exp=001/001/0", rdy, rr_pslverr_s, rr_prdata_s[0]); else pass_cnt++;
    drop(0);
    slave_err = 1'b0;
    tick();
  endtask

  task automatic test_rr_contention();
    logic [8:0] rdy; int t;
    apply_reset();
    req(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 3'b000);
    req(1, 1'b0, 32'h5000_0000, 32'h0, 4'h0, 3'b000);
    req(2, 1'b0, 32'h6000_0000, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_grant, t[3:0]} !== {9'h001, 4'd0, 4'd3}) $display("FAIL rr_first got=%h/%0d/%0d exp=001/0/3", rdy, rr_grant, t); else pass_cnt++;
    drop(0);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_grant, t[3:0]} !== {9'h002, 4'd1, 4'd4}) $display("FAIL rr_second_b2b got=%h/%0d/%0d exp=002/1/4", rdy, rr_grant, t); else pass_cnt++;
    total_cnt++; if (rr_prdata_s[1] !== 32'hDE00_0000) $display("FAIL rr_m1_data got=%h exp=de000000", rr_prdata_s[1]); else pass_cnt++;
    drop(1);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_grant} !== {9'h004, 4'd2}) $display("FAIL rr_third got=%h/%0d exp=004/2", rdy, rr_grant); else pass_cnt++;
    drop(2);
    tick();
  endtask

  task automatic test_rr_wrap();
    logic [8:0] rdy; int t;
    req(8, 1'b0, 32'h8000_0123, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_prdata_s[8]} !== {9'h100, 32'hDE00_0123}) $display("FAIL wrap_m8 got=%h/%h exp=100/de000123", rdy, rr_prdata_s[8]); else pass_cnt++;
    drop(8);
    tick();
    req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000);
    req(8, 1'b0, 32'h8000_0124, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_grant} !== {9'h001, 4'd0}) $display("FAIL wrap_m0_wins got=%h/%0d exp=001/0", rdy, rr_grant); else pass_cnt++;
    drop(0);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if (rdy !== 9'h100) $display("FAIL wrap_m8_after got=%h exp=100", rdy); else pass_cnt++;
    drop(8);
    tick();
  endtask

  task automatic test_fixed_priority();
    logic [8:0] rdy; int t;
    apply_reset();
    req(7, 1'b0, 32'h0000_0777, 32'h0, 4'h0, 3'b000);
    req(4, 1'b0, 32'h0000_0444, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b1, rdy, t);
    total_cnt++; if ({rdy, fp_grant} !== {9'h010, 4'd4}) $display("FAIL fp_first got=%h/%0d exp=010/4", rdy, fp_grant); else pass_cnt++;
    drop(4);
    tick();
    req(4, 1'b0, 32'h0000_0445, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b1, rdy, t);
    total_cnt++; if ({rdy, fp_prdata_s[4]} !== {9'h010, 32'hDE00_0445}) $display("FAIL fp_m4_again got=%h/%h exp=010/de000445", rdy, fp_prdata_s[4]); else pass_cnt++;
    drop(4);
    wait_ready(1'b1, rdy, t);
    total_cnt++; if ({rdy, fp_prdata_s[7]} !== {9'h080, 32'hDE00_0777}) $display("FAIL fp_m7_last got=%h/%h exp=080/de000777", rdy, fp_prdata_s[7]); else pass_cnt++;
    drop(7);
    tick();
  endtask

  task automatic test_timeout();
    logic [8:0] rdy; int t;
    apply_reset();
    req(3, 1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_prdata_s[3], rr_timeout} !== {9'h008, 32'hDE00_0ABC, 1'b0}) $display("FAIL to_normal got=%h/%h/%b exp=008/de000abc/0", rdy, rr_prdata_s[3], rr_timeout); else pass_cnt++;
    drop(3);
    tick();
    slave_ready = 1'b0;
    req(3, 1'b0, 32'h0000_0ABD, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, t[4:0], rr_timeout} !== {9'h008, 5'd10, 1'b1}) $display("FAIL to_fire got=%h/%0d/%b exp=008/10/1", rdy, t, rr_timeout); else pass_cnt++;
    total_cnt++; if ({rr_pslverr_s, rr_prdata_s[3], rr_psel_m} !== {9'h008, 32'h0, 1'b0}) $display("FAIL to_resp got=%h/%h/%b exp=008/0/0", rr_pslverr_s, rr_prdata_s[3], rr_psel_m); else pass_cnt++;
    drop(3);
    tick();
    total_cnt++; if ({rr_timeout, rr_pready_s, rr_busy} !== 11'd0) $display("FAIL to_idle got=%b/%h/%b exp=0/000/0", rr_timeout, rr_pready_s, rr_busy); else pass_cnt++;
    slave_ready = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    logic [8:0] rdy; logic [8:0] seen; int t;
    apply_reset();
    slave_ready = 1'b0;
    req(5, 1'b0, 32'h0000_0555, 32'h0, 4'h0, 3'b000);
    tick(); tick();
    total_cnt++; if ({rr_psel_m, rr_penable_m} !== 2'b11) $display("FAIL mid_in_access got=%b exp=11", {rr_psel_m, rr_penable_m}); else pass_cnt++;
    #2 PRESETn = 1'b0;
    #1;
    total_cnt++; if ({rr_psel_m, rr_penable_m, rr_busy} !== 3'b000) $display("FAIL mid_async_drop got=%b exp=000", {rr_psel_m, rr_penable_m, rr_busy}); else pass_cnt++;
    drop(5);
    tick(); tick();
    PRESETn = 1'b1;
    slave_ready = 1'b1;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | rr_pready_s;
    end
    total_cnt++; if (seen !== 9'h000) $display("FAIL mid_no_resp got=%h exp=000", seen); else pass_cnt++;
    req(7, 1'b0, 32'h0000_0007, 32'h0, 4'h0, 3'b000);
    req(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'b000);
    wait_ready(1'b0, rdy, t);
    total_cnt++; if ({rdy, rr_grant} !== {9'h001, 4'd0}) $display("FAIL mid_post_reset_grant got=%h/%0d exp=001/0", rdy, rr_grant); else pass_cnt++;
    drop(0);
    drop(7);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_rr_contention();
    test_rr_wrap();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
